sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy level, almost-full/almost-empty thresholds, flush and FWFT read mode.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERR_CHK_EN.
module sync_fifo_param #(
    parameter int ADR_BIT   = 3,
    parameter int DAT_BIT   = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_req,
    input  logic [DAT_BIT-1:0] wr_data,
    output logic               wr_full,
    output logic               wr_afull,
    input  logic               rd_req,
    output logic [DAT_BIT-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_empty,
    output logic               rd_aempty,
    output logic [ADR_BIT:0]   level,
    output logic               wr_ovf,
    output logic               rd_udf
);
    localparam int               DEPTH    = 2**ADR_BIT;
    localparam logic [ADR_BIT:0] DEPTH_L  = DEPTH[ADR_BIT:0];
    localparam logic [ADR_BIT:0] AFULL_L  = AFULL_TH[ADR_BIT:0];
    localparam logic [ADR_BIT:0] AEMPTY_L = AEMPTY_TH[ADR_BIT:0];

    logic [DAT_BIT-1:0] mem [DEPTH];
    logic [ADR_BIT:0]   wptr, rptr, lvl;
    logic               wr_acc, rd_acc;

    // Flags decode only from the registered level, never from the requests.
    assign wr_full   = (lvl == DEPTH_L);
    assign wr_afull  = (lvl >= AFULL_L);
    assign rd_empty  = (lvl == '0);
    assign rd_aempty = (lvl <= AEMPTY_L);
    assign level     = lvl;

    assign wr_acc = wr_req && !wr_full  && !flush;
    assign rd_acc = rd_req && !rd_empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[ADR_BIT-1:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rptr[ADR_BIT-1:0]];
            assign rd_valid = !rd_empty;
        end else begin : g_reg
            logic [DAT_BIT-1:0] dat_q;
            logic               vld_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) dat_q <= mem[rptr[ADR_BIT-1:0]];
                end
            end
            assign rd_data  = dat_q;
            assign rd_valid = vld_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_CHK_EN
    logic ovf_q, udf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_req && wr_full)  ovf_q <= 1'b1;
            if (rd_req && rd_empty) udf_q <= 1'b1;
        end
    end
    assign wr_ovf = ovf_q;
    assign rd_udf = udf_q;
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && !flush && wr_req && wr_full)  $warning("sync_fifo_param: write while full");
        if (rst_n && !flush && rd_req && rd_empty) $warning("sync_fifo_param: read while empty");
    end
`endif
`else
    assign wr_ovf = 1'b0;
    assign rd_udf = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read and an FWFT instance driven by the same stimulus.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n, flush, wr_req, rd_req;
    logic [7:0] wr_data;

    logic       r_full, r_afull, r_valid, r_empty, r_aempty, r_ovf, r_udf;
    logic [7:0] r_data;
    logic [3:0] r_level;
    logic       f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_udf;
    logic [7:0] f_data;
    logic [3:0] f_level;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SYNC_FIFO_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sync_fifo_param #(.ADR_BIT(3), .DAT_BIT(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_data(wr_data),
        .wr_full(r_full), .wr_afull(r_afull), .rd_req(rd_req), .rd_data(r_data),
        .rd_valid(r_valid), .rd_empty(r_empty), .rd_aempty(r_aempty), .level(r_level),
        .wr_ovf(r_ovf), .rd_udf(r_udf));

    sync_fifo_param #(.ADR_BIT(3), .DAT_BIT(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_data(wr_data),
        .wr_full(f_full), .wr_afull(f_afull), .rd_req(rd_req), .rd_data(f_data),
        .rd_valid(f_valid), .rd_empty(f_empty), .rd_aempty(f_aempty), .level(f_level),
        .wr_ovf(f_ovf), .rd_udf(f_udf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " level"},  32'(r_level), 0);
        chk({tag, " full"},   32'(r_full), 0);
        chk({tag, " afull"},  32'(r_afull), 0);
        chk({tag, " empty"},  32'(r_empty), 1);
        chk({tag, " aempty"}, 32'(r_aempty), 1);
        chk({tag, " valid"},  32'(r_valid), 0);
        chk({tag, " data"},   32'(r_data), 0);
        chk({tag, " ovf"},    32'(r_ovf), 0);
        chk({tag, " udf"},    32'(r_udf), 0);
        chk({tag, " f_empty"}, 32'(f_empty), 1);
    endtask

    logic [7:0] sb[$];
    logic [7:0] exp_d;
    logic       wacc, racc;
    int         nwr, cyc;

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        tick(); tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            wr_req = 1'b1; wr_data = 8'(i * 8'h11);
            tick();
            chk($sformatf("fill%0d level", i), 32'(r_level), i);
            chk($sformatf("fill%0d afull", i), 32'(r_afull), (i >= 6) ? 1 : 0);
            chk($sformatf("fill%0d full", i),  32'(r_full), (i == 8) ? 1 : 0);
        end
        wr_req = 1'b0;
        chk("fwft head", 32'(f_data), 32'h11);

        for (int i = 1; i <= 8; i++) begin
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
            chk($sformatf("rd%0d valid", i), 32'(r_valid), 1);
            chk($sformatf("rd%0d data", i),  32'(r_data), 32'(i * 8'h11));
            chk($sformatf("rd%0d level", i), 32'(r_level), 8 - i);
            tick();
            chk($sformatf("rd%0d pulse", i), 32'(r_valid), 0);
        end
        chk("drain empty", 32'(r_empty), 1);

        // FWFT single word
        wr_req = 1'b1; wr_data = 8'hA5;
        tick();
        wr_req = 1'b0;
        chk("fwft data", 32'(f_data), 32'hA5);
        chk("fwft valid", 32'(f_valid), 1);
        tick();
        chk("fwft hold", 32'(f_data), 32'hA5);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("fwft pop empty", 32'(f_empty), 1);
        chk("fwft pop valid", 32'(f_valid), 0);
        chk("reg a5 data", 32'(r_data), 32'hA5);

        // full + simultaneous read/write
        for (int i = 0; i < 8; i++) begin
            wr_req = 1'b1; wr_data = 8'(8'h20 + i);
            tick();
        end
        chk("full2", 32'(r_full), 1);
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hEE;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("full rw level", 32'(r_level), 7);
        chk("full rw data",  32'(r_data), 32'h20);
        chk("full rw valid", 32'(r_valid), 1);
        chk("wr_ovf", 32'(r_ovf), 32'(ERR_EXP));
        for (int i = 1; i <= 7; i++) begin
            rd_req = 1'b1;
            tick();
            chk($sformatf("full rd%0d", i), 32'(r_data), 32'(8'h20 + i));
        end
        rd_req = 1'b0;
        chk("ee not stored", 32'(r_empty), 1);

        // empty + simultaneous read/write
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h3C;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("empty rw level", 32'(r_level), 1);
        chk("empty rw valid", 32'(r_valid), 0);
        chk("rd_udf", 32'(r_udf), 32'(ERR_EXP));
        chk("wr_ovf sticky", 32'(r_ovf), 32'(ERR_EXP));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("3c data", 32'(r_data), 32'h3C);
        chk("3c valid", 32'(r_valid), 1);

        // pointer wrap: write every cycle, read 2 of 3 cycles, scoreboard
        nwr = 0; cyc = 0;
        while ((nwr < 20 || sb.size() != 0) && cyc < 200) begin
            wr_req  = (nwr < 20);
            wr_data = 8'(8'h40 + nwr * 7);
            rd_req  = (nwr >= 20) || (cyc % 3 != 0);
            wacc = wr_req && !r_full;
            racc = rd_req && !r_empty;
            if (racc) exp_d = sb.pop_front();
            if (wacc) begin sb.push_back(wr_data); nwr++; end
            tick();
            cyc++;
            if (racc) chk($sformatf("wrap data c%0d", cyc), 32'(r_data), 32'(exp_d));
            chk($sformatf("wrap valid c%0d", cyc), 32'(r_valid), 32'(racc));
            chk($sformatf("wrap level c%0d", cyc), 32'(r_level), sb.size());
            chk($sformatf("wrap bound c%0d", cyc), 32'(r_level <= 4'd8), 1);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("wrap budget", 32'(cyc < 200), 1);

        // flush with simultaneous write
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        flush = 1'b1; wr_req = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_req = 1'b0;
        chk("flush level", 32'(r_level), 0);
        chk("flush empty", 32'(r_empty), 1);
        chk("flush valid", 32'(r_valid), 0);
        chk("flush data hold", 32'(r_data), 32'h60);
        chk("flush ovf", 32'(r_ovf), 0);
        chk("flush udf", 32'(r_udf), 0);
        wr_req = 1'b1; wr_data = 8'h5A;
        tick();
        wr_req = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("post flush data", 32'(r_data), 32'h5A);
        chk("post flush empty", 32'(r_empty), 1);

        // async reset mid-burst
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_data = 8'(8'h70 + i);
            tick();
        end
        rd_req = 1'b1;
        tick();
        chk("pre-rst level", 32'(r_level), 4);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async rst");
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr_req = 1'b1; wr_data = 8'hC3;
        tick();
        wr_req = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("post rst data", 32'(r_data), 32'hC3);
        chk("post rst level", 32'(r_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
